// File: rtl/text_pkg.sv
// Shared constants and types for the character-cell text overlay.
// Glyph geometry and font ROM latency are fixed properties of the attached font ROM.
package text_pkg;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam int         GLYPH_W     = 8;
  localparam int         GLYPH_H     = 8;
  localparam int         ROM_LATENCY = 1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

endpackage

// File: rtl/text_buffer.sv
// Writable character buffer: register array reset to spaces, one write port,
// combinational read port for the renderer, and a one-entry-per-cycle clear sweep.
module text_buffer
  import text_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 2,
  parameter int AW   = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_char,
  input  logic          clear,
  output logic          busy,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char
);

  localparam int DEPTH = COLS * ROWS;

  logic [7:0]    mem [DEPTH];
  clr_state_t    state_reg;
  clr_state_t    state_next;
  logic [AW-1:0] count_reg;
  logic          clr_we;
  logic          host_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A clear request takes priority over a same-cycle host write.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    clr_we     = 1'b0;
    host_we    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear) begin
          state_next = ST_CLEAR;
        end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
          host_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (count_reg == AW'(DEPTH - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr_we && state_next == ST_CLEAR) begin
      count_reg <= count_reg + 1'b1;
    end else begin
      count_reg <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= CHAR_SPACE;
      end
    end else if (clr_we) begin
      mem[count_reg] <= CHAR_SPACE;
    end else if (host_we) begin
      mem[wr_addr] <= wr_char;
    end
  end

  // Unregistered read so the renderer's stage-1 register sees the pre-write value.
  assign rd_char = mem[rd_addr];

endmodule

// File: rtl/text_overlay.sv
// Text window decode and 3-stage render pipeline around an external font ROM:
// buffer lookup -> ROM fetch -> glyph bit select, with de delayed to match.
module text_overlay
  import text_pkg::*;
#(
  parameter int X0         = 64,
  parameter int Y0         = 48,
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int SCALE_LOG2 = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    pixel_x,
  input  logic [9:0]                    pixel_y,
  input  logic                          de_in,
  input  logic                          wr_en,
  input  logic [$clog2(COLS*ROWS)-1:0]  wr_addr,
  input  logic [7:0]                    wr_char,
  input  logic                          clear,
  output logic                          busy,
  output logic [7:0]                    ascii,
  output logic [3:0]                    row,
  input  logic [7:0]                    pixels,
  output logic                          text_on,
  output logic                          de_out
);

  localparam int AW    = $clog2(COLS * ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int LW    = $clog2(ROWS);
  localparam int GX    = $clog2(GLYPH_W);
  localparam int GY    = $clog2(GLYPH_H);
  localparam int SX    = GX + SCALE_LOG2;
  localparam int SY    = GY + SCALE_LOG2;
  localparam int DEPTH = ROM_LATENCY + 1;

  localparam logic [10:0]   X_LO    = 11'(X0);
  localparam logic [10:0]   X_HI    = 11'(X0 + (COLS << SX));
  localparam logic [10:0]   Y_LO    = 11'(Y0);
  localparam logic [10:0]   Y_HI    = 11'(Y0 + (ROWS << SY));
  localparam logic [GX-1:0] BIT_MSB = GX'(GLYPH_W - 1);

  logic [9:0]    rx;
  logic [9:0]    ry;
  logic          in_win;
  logic [CW-1:0] col;
  logic [LW-1:0] text_line;
  logic [GY-1:0] glyph_row;
  logic [GX-1:0] bit_idx;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_char;
  logic          coord_unused;

  assign in_win = de_in
                & ({1'b0, pixel_x} >= X_LO) & ({1'b0, pixel_x} < X_HI)
                & ({1'b0, pixel_y} >= Y_LO) & ({1'b0, pixel_y} < Y_HI);

  assign rx        = pixel_x - X_LO[9:0];
  assign ry        = pixel_y - Y_LO[9:0];
  assign col       = rx[SX +: CW];
  assign text_line = ry[SY +: LW];
  assign glyph_row = ry[SCALE_LOG2 +: GY];
  assign bit_idx   = rx[SCALE_LOG2 +: GX];
  assign rd_addr   = {text_line, col};

  // Only some relative-coordinate bits feed the decode; the rest are don't-care.
  assign coord_unused = ^{rx, ry};

  text_buffer #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .clear   (clear),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_char (rd_char)
  );

  logic          in_win_pipe  [DEPTH];
  logic          de_pipe      [DEPTH];
  logic [GX-1:0] bit_idx_pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii           <= CHAR_SPACE;
      row             <= 4'd0;
      in_win_pipe[0]  <= 1'b0;
      de_pipe[0]      <= 1'b0;
      bit_idx_pipe[0] <= '0;
    end else begin
      if (in_win) begin
        ascii <= rd_char;
        row   <= 4'(glyph_row);
      end else begin
        ascii <= CHAR_SPACE;
        row   <= 4'd0;
      end
      in_win_pipe[0]  <= in_win;
      de_pipe[0]      <= de_in;
      bit_idx_pipe[0] <= bit_idx;
    end
  end

  // Delay line that covers the font ROM read latency.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_rom_delay
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_win_pipe[gi]  <= 1'b0;
        de_pipe[gi]      <= 1'b0;
        bit_idx_pipe[gi] <= '0;
      end else begin
        in_win_pipe[gi]  <= in_win_pipe[gi-1];
        de_pipe[gi]      <= de_pipe[gi-1];
        bit_idx_pipe[gi] <= bit_idx_pipe[gi-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_on <= 1'b0;
      de_out  <= 1'b0;
    end else begin
      text_on <= in_win_pipe[DEPTH-1] & pixels[BIT_MSB - bit_idx_pipe[DEPTH-1]];
      de_out  <= de_pipe[DEPTH-1];
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay with a 1-cycle font ROM model and a
// scoreboard of expected ascii/row and text_on/de_out per driven pixel.
module tb_text_overlay;

  localparam int X0   = 64;
  localparam int Y0   = 48;
  localparam int COLS = 16;
  localparam int ROWS = 2;
  localparam int S    = 1;
  localparam int N    = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       de_in = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       clear = 1'b0;
  logic       busy;
  logic [7:0] ascii;
  logic [3:0] row;
  logic [7:0] pixels = '0;
  logic       text_on;
  logic       de_out;

  text_overlay #(
    .X0 (X0), .Y0 (Y0), .COLS (COLS), .ROWS (ROWS), .SCALE_LOG2 (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .de_in   (de_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .clear   (clear),
    .busy    (busy),
    .ascii   (ascii),
    .row     (row),
    .pixels  (pixels),
    .text_on (text_on),
    .de_out  (de_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font(input logic [7:0] c, input logic [3:0] r);
    logic [7:0] g;
    g = 8'h00;
    case (c)
      8'h20: g = 8'h00;
      8'h41: case (r)
        4'd0: g = 8'h30; 4'd1: g = 8'h78; 4'd2: g = 8'hCC; 4'd3: g = 8'hCC;
        4'd4: g = 8'hFC; 4'd5: g = 8'hCC; 4'd6: g = 8'hCC; default: g = 8'h00;
      endcase
      8'h42: case (r)
        4'd0: g = 8'hFC; 4'd1: g = 8'h66; 4'd2: g = 8'h66; 4'd3: g = 8'h7C;
        4'd4: g = 8'h66; 4'd5: g = 8'h66; 4'd6: g = 8'hFC; default: g = 8'h00;
      endcase
      default: g = c ^ {r, r};
    endcase
    return g;
  endfunction

  // Font ROM model: one cycle of read latency.
  always @(posedge clk) pixels <= font(ascii, row);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct { int due; logic [7:0] a; logic [3:0] r; } fe_t;
  typedef struct { int due; logic t; logic d; } be_t;
  fe_t fe_q[$];
  be_t be_q[$];
  fe_t fe_e;
  be_t be_e;

  logic [7:0] mbuf [N];
  int busy_left = 0;

  always @(negedge clk) begin
    while (fe_q.size() > 0 && fe_q[0].due <= cyc) begin
      fe_e = fe_q.pop_front();
      chk("ascii", 32'(ascii), 32'(fe_e.a));
      chk("row", 32'(row), 32'(fe_e.r));
    end
    while (be_q.size() > 0 && be_q[0].due <= cyc) begin
      be_e = be_q.pop_front();
      chk("text_on", 32'(text_on), 32'(be_e.t));
      chk("de_out", 32'(de_out), 32'(be_e.d));
    end
  end

  task automatic step(input int x, input int y, input bit de, input bit we,
                      input int wa, input logic [7:0] wc, input bit clr);
    bit         win;
    int         rx, ry, addr, bi;
    logic [7:0] ea, g;
    logic [3:0] er;
    bit         et;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(busy_left > 0));
    pixel_x = 10'(x); pixel_y = 10'(y); de_in = de;
    wr_en = we; wr_addr = 5'(wa); wr_char = wc; clear = clr;
    win = de && x >= X0 && x < X0 + (COLS << (3 + S)) && y >= Y0 && y < Y0 + (ROWS << (3 + S));
    rx = x - X0; ry = y - Y0;
    ea = 8'h20; er = 4'd0; et = 1'b0;
    if (win) begin
      addr = (ry >> (3 + S)) * COLS + (rx >> (3 + S));
      ea   = mbuf[addr];
      er   = 4'((ry >> S) & 7);
      bi   = (rx >> S) & 7;
      g    = font(ea, er);
      et   = g[7 - bi];
    end
    fe_q.push_back('{due: cyc + 1, a: ea, r: er});
    be_q.push_back('{due: cyc + 3, t: et, d: de});
    if (busy_left > 0) busy_left--;
    else if (clr) begin
      busy_left = N;
      for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    end else if (we && wa < N) mbuf[wa] = wc;
  endtask

  task automatic scan(input int x, input int y, input bit de);
    step(x, y, de, 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic write_char(input int a, input logic [7:0] c);
    step(0, 0, 1'b0, 1'b1, a, c, 1'b0);
  endtask

  task automatic idle();
    step(0, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic scan_cells();
    for (int a = 0; a < N; a++) scan(X0 + (a % COLS) * 16, Y0 + (a / COLS) * 16, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ascii"}, 32'(ascii), 32'h20);
    chk({tag, "_row"}, 32'(row), 32'd0);
    chk({tag, "_text_on"}, 32'(text_on), 32'd0);
    chk({tag, "_de_out"}, 32'(de_out), 32'd0);
  endtask

  // Counts busy cycles after a clear pulse, bounded in case busy never drops.
  task automatic measure_clear(input string tag, input int wr_at);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step(0, 0, 1'b0, k == wr_at, 5, 8'h5A, 1'b0);
      if (busy) n++;
      else break;
    end
    chk(tag, 32'(n), 32'd32);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;

    // 1: reset values, then a full window scan of spaces
    @(negedge clk); @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int y = Y0; y < Y0 + 32; y++)
      for (int x = X0; x < X0 + 256; x++) scan(x, y, 1'b1);

    // 2/3: 'B' at cell 0 and several glyph positions
    write_char(0, 8'h42);
    scan(64, 48, 1'b1);
    scan(66, 48, 1'b1);
    scan(76, 48, 1'b1);
    scan(64, 62, 1'b1);
    // same-cycle read/write returns the old value, then the new one
    step(80, 48, 1'b1, 1'b1, 1, 8'h43, 1'b0);
    scan(80, 48, 1'b1);
    write_char(31, 8'h41);
    scan(304, 64, 1'b1);
    scan(306, 74, 1'b1);

    // 4: window edges and de_in low
    scan(320, 48, 1'b1);
    scan(63, 48, 1'b1);
    scan(64, 80, 1'b1);
    scan(64, 47, 1'b1);
    scan(319, 79, 1'b1);
    scan(64, 48, 1'b0);

    // 5: clear with buffer full of 'A'; clear beats a same-cycle write, sweep drops writes
    for (int a = 0; a < N; a++) write_char(a, 8'h41);
    scan_cells();
    step(0, 0, 1'b0, 1'b1, 3, 8'h51, 1'b1);
    measure_clear("clear_len", 5);
    scan_cells();

    // 6: reset in the middle of a sweep
    for (int a = 0; a < N; a++) write_char(a, 8'h41);
    step(0, 0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    repeat (11) idle();
    #2 rst = 1'b1;
    #1 check_reset_outputs("midclear");
    fe_q.delete();
    be_q.delete();
    busy_left = 0;
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    @(negedge clk);
    rst = 1'b0;
    scan_cells();
    write_char(7, 8'h42);
    step(0, 0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    measure_clear("clear_len_after_reset", -1);
    scan_cells();

    repeat (5) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
